// File: rtl/soe_to_si_10_hrx2.sv
// Receive end of the 10-element half-rate series link: gathers two 5-element
// beats and presents them as one registered parallel vector with a valid pulse.
module soe_to_si_10_hrx2 #(
  parameter int IN_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       inReady,
  input  logic                       inSeries,
  input  logic signed [IN_WIDTH-1:0] S0,
  input  logic signed [IN_WIDTH-1:0] S1,
  input  logic signed [IN_WIDTH-1:0] S2,
  input  logic signed [IN_WIDTH-1:0] S3,
  input  logic signed [IN_WIDTH-1:0] S4,
  output logic                       readyForNewDataSeries,
  output logic signed [IN_WIDTH-1:0] O0,
  output logic signed [IN_WIDTH-1:0] O1,
  output logic signed [IN_WIDTH-1:0] O2,
  output logic signed [IN_WIDTH-1:0] O3,
  output logic signed [IN_WIDTH-1:0] O4,
  output logic signed [IN_WIDTH-1:0] O5,
  output logic signed [IN_WIDTH-1:0] O6,
  output logic signed [IN_WIDTH-1:0] O7,
  output logic signed [IN_WIDTH-1:0] O8,
  output logic signed [IN_WIDTH-1:0] O9,
  output logic                       outReady,
  output logic                       earlyOutReady,
  output logic                       frameError
);

  typedef enum logic {
    WAIT_LO = 1'b0,
    WAIT_HI = 1'b1
  } state_t;

  state_t                      state;
  logic signed [IN_WIDTH-1:0]  beatIn [5];
  logic signed [IN_WIDTH-1:0]  loReg  [5];
  logic signed [IN_WIDTH-1:0]  outVec [10];
  logic                        acc;
  logic                        takeHi;
  logic                        badBeat;

  assign beatIn[0] = S0;
  assign beatIn[1] = S1;
  assign beatIn[2] = S2;
  assign beatIn[3] = S3;
  assign beatIn[4] = S4;

  assign O0 = outVec[0];
  assign O1 = outVec[1];
  assign O2 = outVec[2];
  assign O3 = outVec[3];
  assign O4 = outVec[4];
  assign O5 = outVec[5];
  assign O6 = outVec[6];
  assign O7 = outVec[7];
  assign O8 = outVec[8];
  assign O9 = outVec[9];

  assign acc    = enable & inReady;
  assign takeHi = acc & ~inSeries & (state == WAIT_HI);
  // A beat-1 with no pending beat-0, or a beat-0 while one is already pending.
  assign badBeat = acc & ((state == WAIT_LO) ? ~inSeries : inSeries);

  assign readyForNewDataSeries = (state == WAIT_LO);
  assign earlyOutReady         = takeHi;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_LO;
      outReady   <= 1'b0;
      frameError <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        loReg[i] <= '0;
      end
      for (int i = 0; i < 10; i++) begin
        outVec[i] <= '0;
      end
    end else if (enable) begin
      outReady   <= takeHi;
      frameError <= badBeat;
      case (state)
        WAIT_LO: begin
          if (inReady && inSeries) begin
            for (int i = 0; i < 5; i++) begin
              loReg[i] <= beatIn[i];
            end
            state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (inReady && inSeries) begin
            // Restart: the newer beat 0 replaces the pending one.
            for (int i = 0; i < 5; i++) begin
              loReg[i] <= beatIn[i];
            end
          end else if (inReady) begin
            for (int i = 0; i < 5; i++) begin
              outVec[i]     <= loReg[i];
              outVec[i + 5] <= beatIn[i];
            end
            state <= WAIT_LO;
          end
        end
        default: state <= WAIT_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_soe_to_si_10_hrx2.sv
// Directed bench for the 10-element half-rate deserializer: one task per scenario,
// inline comparisons against hand-computed vectors.
module tb_soe_to_si_10_hrx2;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              inReady;
  logic              inSeries;
  logic signed [9:0] s [5];
  logic signed [9:0] o [10];
  logic              readyForNewDataSeries;
  logic              outReady;
  logic              earlyOutReady;
  logic              frameError;

  int nTests = 0;
  int nFail  = 0;

  soe_to_si_10_hrx2 #(.IN_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .enable(enable), .inReady(inReady), .inSeries(inSeries),
    .S0(s[0]), .S1(s[1]), .S2(s[2]), .S3(s[3]), .S4(s[4]),
    .readyForNewDataSeries(readyForNewDataSeries),
    .O0(o[0]), .O1(o[1]), .O2(o[2]), .O3(o[3]), .O4(o[4]),
    .O5(o[5]), .O6(o[6]), .O7(o[7]), .O8(o[8]), .O9(o[9]),
    .outReady(outReady), .earlyOutReady(earlyOutReady), .frameError(frameError)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setBeat(input logic en, input logic rdy, input logic ser,
                         input int v0, input int v1, input int v2, input int v3, input int v4);
    enable   = en;
    inReady  = rdy;
    inSeries = ser;
    s[0] = v0[9:0];
    s[1] = v1[9:0];
    s[2] = v2[9:0];
    s[3] = v3[9:0];
    s[4] = v4[9:0];
  endtask

  task automatic setIdle;
    setBeat(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    setIdle();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    nTests++;
    if (readyForNewDataSeries !== 1'b1 || outReady !== 1'b0 || frameError !== 1'b0 || earlyOutReady !== 1'b0) begin
      nFail++;
      $display("FAIL reset_flags: got rdy=%b out=%b fe=%b early=%b, want 1 0 0 0",
               readyForNewDataSeries, outReady, frameError, earlyOutReady);
    end
    for (int i = 0; i < 10; i++) begin
      nTests++;
      if (o[i] !== 10'sd0) begin
        nFail++;
        $display("FAIL reset_O%0d: got %0d, want 0", i, o[i]);
      end
    end
    tick();
    tick();
    #2 reset = 1'b1;
    tick();
    $display("[TB] reset checked");
  endtask

  task automatic test_basic;
    logic signed [9:0] exp [10];
    for (int i = 0; i < 9; i++) exp[i] = 10'(i + 1);
    exp[9] = -10'sd10;
    setBeat(1, 1, 1, 1, 2, 3, 4, 5);
    #1;
    nTests++;
    if (earlyOutReady !== 1'b0 || readyForNewDataSeries !== 1'b1) begin
      nFail++;
      $display("FAIL basic_beat0: got early=%b rdy=%b, want 0 1", earlyOutReady, readyForNewDataSeries);
    end
    tick();
    setBeat(1, 1, 0, 6, 7, 8, 9, -10);
    #1;
    nTests++;
    if (earlyOutReady !== 1'b1 || readyForNewDataSeries !== 1'b0 || outReady !== 1'b0) begin
      nFail++;
      $display("FAIL basic_beat1: got early=%b rdy=%b out=%b, want 1 0 0",
               earlyOutReady, readyForNewDataSeries, outReady);
    end
    tick();
    setIdle();
    #1;
    nTests++;
    if (outReady !== 1'b1 || readyForNewDataSeries !== 1'b1) begin
      nFail++;
      $display("FAIL basic_outReady: got out=%b rdy=%b, want 1 1", outReady, readyForNewDataSeries);
    end
    for (int i = 0; i < 10; i++) begin
      nTests++;
      if (o[i] !== exp[i]) begin
        nFail++;
        $display("FAIL basic_O%0d: got %0d, want %0d", i, o[i], exp[i]);
      end
    end
    tick();
    nTests++;
    if (outReady !== 1'b0) begin
      nFail++;
      $display("FAIL basic_pulse_end: got out=%b, want 0", outReady);
    end
    for (int i = 0; i < 10; i++) begin
      nTests++;
      if (o[i] !== exp[i]) begin
        nFail++;
        $display("FAIL basic_hold_O%0d: got %0d, want %0d", i, o[i], exp[i]);
      end
    end
    $display("[TB] basic series checked");
  endtask

  task automatic test_back_to_back;
    for (int k = 1; k <= 4; k++) begin
      if (k <= 3) setBeat(1, 1, 1, 10*k, 10*k+1, 10*k+2, 10*k+3, 10*k+4);
      else        setIdle();
      #1;
      nTests++;
      if (readyForNewDataSeries !== 1'b1 || outReady !== (k > 1)) begin
        nFail++;
        $display("FAIL b2b_beat0_k%0d: got rdy=%b out=%b, want 1 %b",
                 k, readyForNewDataSeries, outReady, (k > 1));
      end
      if (k > 1) begin
        for (int i = 0; i < 10; i++) begin
          nTests++;
          if (o[i] !== 10'(10*(k-1) + i)) begin
            nFail++;
            $display("FAIL b2b_vec%0d_O%0d: got %0d, want %0d", k-1, i, o[i], 10*(k-1) + i);
          end
        end
      end
      if (k == 4) break;
      tick();
      setBeat(1, 1, 0, 10*k+5, 10*k+6, 10*k+7, 10*k+8, 10*k+9);
      #1;
      nTests++;
      if (readyForNewDataSeries !== 1'b0 || outReady !== 1'b0 || earlyOutReady !== 1'b1) begin
        nFail++;
        $display("FAIL b2b_beat1_k%0d: got rdy=%b out=%b early=%b, want 0 0 1",
                 k, readyForNewDataSeries, outReady, earlyOutReady);
      end
      tick();
    end
    tick();
    $display("[TB] back-to-back checked");
  endtask

  task automatic test_gap_freeze;
    setBeat(1, 1, 1, 100, -101, 102, -103, 104);
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c < 3) setIdle();
      else       setBeat(0, 1, (c == 3), 77, 77, 77, 77, 77);
      #1;
      nTests++;
      if (readyForNewDataSeries !== 1'b0 || outReady !== 1'b0 || earlyOutReady !== 1'b0 || frameError !== 1'b0) begin
        nFail++;
        $display("FAIL gap_cycle%0d: got rdy=%b out=%b early=%b fe=%b, want 0 0 0 0",
                 c, readyForNewDataSeries, outReady, earlyOutReady, frameError);
      end
      tick();
    end
    setBeat(1, 1, 0, -200, 201, -202, 203, -204);
    #1;
    nTests++;
    if (earlyOutReady !== 1'b1) begin
      nFail++;
      $display("FAIL gap_early: got %b, want 1", earlyOutReady);
    end
    tick();
    setBeat(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    nTests++;
    if (outReady !== 1'b1 || o[0] !== 10'sd100 || o[3] !== -10'sd103 || o[5] !== -10'sd200 || o[9] !== -10'sd204) begin
      nFail++;
      $display("FAIL gap_vector: got out=%b O0=%0d O3=%0d O5=%0d O9=%0d, want 1 100 -103 -200 -204",
               outReady, o[0], o[3], o[5], o[9]);
    end
    tick();
    nTests++;
    if (outReady !== 1'b1) begin
      nFail++;
      $display("FAIL freeze_hold_outReady: got %b, want 1", outReady);
    end
    setIdle();
    tick();
    nTests++;
    if (outReady !== 1'b0) begin
      nFail++;
      $display("FAIL gap_single_pulse: got %b, want 0", outReady);
    end
    $display("[TB] gap and freeze checked");
  endtask

  task automatic test_frame_error;
    setBeat(1, 1, 0, 9, 9, 9, 9, 9);
    #1;
    nTests++;
    if (earlyOutReady !== 1'b0) begin
      nFail++;
      $display("FAIL fe_stray_early: got %b, want 0", earlyOutReady);
    end
    tick();
    setIdle();
    #1;
    nTests++;
    if (frameError !== 1'b1 || readyForNewDataSeries !== 1'b1 || outReady !== 1'b0 || o[0] !== 10'sd100 || o[9] !== -10'sd204) begin
      nFail++;
      $display("FAIL fe_stray: got fe=%b rdy=%b out=%b O0=%0d O9=%0d, want 1 1 0 100 -204",
               frameError, readyForNewDataSeries, outReady, o[0], o[9]);
    end
    tick();
    nTests++;
    if (frameError !== 1'b0) begin
      nFail++;
      $display("FAIL fe_clear: got %b, want 0", frameError);
    end
    setBeat(1, 1, 1, 1, 1, 1, 1, 1);
    tick();
    setBeat(1, 1, 1, 21, 22, 23, 24, 25);
    #1;
    nTests++;
    if (readyForNewDataSeries !== 1'b0 || frameError !== 1'b0) begin
      nFail++;
      $display("FAIL fe_restart_pre: got rdy=%b fe=%b, want 0 0", readyForNewDataSeries, frameError);
    end
    tick();
    setBeat(1, 1, 0, 26, 27, 28, 29, 30);
    #1;
    nTests++;
    if (frameError !== 1'b1 || earlyOutReady !== 1'b1) begin
      nFail++;
      $display("FAIL fe_restart: got fe=%b early=%b, want 1 1", frameError, earlyOutReady);
    end
    tick();
    setIdle();
    #1;
    nTests++;
    if (frameError !== 1'b0 || outReady !== 1'b1) begin
      nFail++;
      $display("FAIL fe_restart_done: got fe=%b out=%b, want 0 1", frameError, outReady);
    end
    for (int i = 0; i < 10; i++) begin
      nTests++;
      if (o[i] !== 10'(21 + i)) begin
        nFail++;
        $display("FAIL fe_restart_O%0d: got %0d, want %0d", i, o[i], 21 + i);
      end
    end
    tick();
    $display("[TB] frame errors checked");
  endtask

  task automatic test_async_reset;
    setBeat(1, 1, 1, 11, 22, 33, 44, 55);
    tick();
    setBeat(1, 1, 0, 66, 77, 88, 99, -111);
    tick();
    setBeat(1, 1, 1, -1, -2, -3, -4, -5);
    #1;
    nTests++;
    if (outReady !== 1'b1 || o[0] !== 10'sd11) begin
      nFail++;
      $display("FAIL ar_pre_vector: got out=%b O0=%0d, want 1 11", outReady, o[0]);
    end
    tick();
    setIdle();
    #1;
    nTests++;
    if (readyForNewDataSeries !== 1'b0) begin
      nFail++;
      $display("FAIL ar_pending: got rdy=%b, want 0", readyForNewDataSeries);
    end
    #2 reset = 1'b0;
    #1;
    nTests++;
    if (readyForNewDataSeries !== 1'b1 || outReady !== 1'b0 || frameError !== 1'b0) begin
      nFail++;
      $display("FAIL ar_flags: got rdy=%b out=%b fe=%b, want 1 0 0", readyForNewDataSeries, outReady, frameError);
    end
    for (int i = 0; i < 10; i++) begin
      nTests++;
      if (o[i] !== 10'sd0) begin
        nFail++;
        $display("FAIL ar_O%0d: got %0d, want 0", i, o[i]);
      end
    end
    #2 reset = 1'b1;
    tick();
    setBeat(1, 1, 0, 5, 5, 5, 5, 5);
    tick();
    setIdle();
    #1;
    nTests++;
    if (frameError !== 1'b1 || outReady !== 1'b0) begin
      nFail++;
      $display("FAIL ar_lost_partial: got fe=%b out=%b, want 1 0", frameError, outReady);
    end
    tick();
    $display("[TB] async reset checked");
  endtask

  task automatic test_extremes;
    setBeat(1, 1, 1, -512, -512, -512, -512, -512);
    tick();
    setBeat(1, 1, 0, 511, 511, 511, 511, 511);
    tick();
    setIdle();
    #1;
    nTests++;
    if (outReady !== 1'b1) begin
      nFail++;
      $display("FAIL ext_outReady: got %b, want 1", outReady);
    end
    for (int i = 0; i < 10; i++) begin
      nTests++;
      if (o[i] !== ((i < 5) ? 10'h200 : 10'h1FF)) begin
        nFail++;
        $display("FAIL ext_O%0d: got %h, want %h", i, o[i], (i < 5) ? 10'h200 : 10'h1FF);
      end
    end
    tick();
    $display("[TB] extremes checked");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gap_freeze();
    test_frame_error();
    test_async_reset();
    test_extremes();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/soe_to_si_10_hrx2.md
Name: soe_to_si_10_hrx2

Overview:
- Series-to-parallel deserializer, the receive end of the 10-element half-rate (x2) series interface.
- Collects two consecutive 5-element beats (S0..S4) and presents one registered 10-element parallel vector (O0..O9) with a one-cycle valid pulse.
- Sits downstream of series-domain arithmetic (e.g. vector add on 5-wide series) to restore parallel form for parallel-input consumers.

Parameters:
- IN_WIDTH, 10, bit width of each signed element on input and output (instantiate as IN_WIDTH+1 behind an adder).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  global clock enable; low freezes all state and outputs
- inReady  input  1  a beat is present on S0..S4 this cycle
- inSeries  input  1  high on beat 0 (first half) of a series, low on beat 1
- S0..S4  input  IN_WIDTH each, signed  current beat elements
- readyForNewDataSeries  output  1  block is expecting beat 0
- O0..O9  output  IN_WIDTH each, signed  assembled vector (O0..O4 = beat 0, O5..O9 = beat 1)
- outReady  output  1  registered; O0..O9 updated with a complete vector
- earlyOutReady  output  1  combinational; beat 1 is being accepted this cycle
- frameError  output  1  registered one-cycle pulse on a protocol violation

Behaviour:
- Reset (reset=0, async): state=WAIT_LO, lo holding regs=0, O0..O9=0, outReady=0, frameError=0. A partial series is discarded. Deassertion is sampled at the next clk edge.
- The beat qualifier is acc = enable & inReady.
- enable=0: state, holding regs, O0..O9, outReady and frameError all hold their values. earlyOutReady=0.
- readyForNewDataSeries = (state==WAIT_LO). It is combinational and independent of enable.
- State WAIT_LO:
  - acc & inSeries: S0..S4 latch into lo regs; next state WAIT_HI.
  - acc & !inSeries: beat discarded; frameError=1 next cycle; state stays WAIT_LO.
- State WAIT_HI:
  - acc & !inSeries: O0..O4 <= lo regs and O5..O9 <= S0..S4 at the edge; outReady=1 next cycle; next state WAIT_LO.
  - acc & inSeries: restart. Lo regs are overwritten with the new beat; frameError=1 next cycle; state stays WAIT_HI; no output.
- earlyOutReady = enable & inReady & !inSeries & (state==WAIT_HI).
- outReady and frameError are single-cycle pulses whenever enable=1. They clear on the next enabled edge unless retriggered.
- Latency: outReady rises on the edge that accepts beat 1, so it is seen the cycle after earlyOutReady. O0..O9 are valid in that same cycle.
- Data handling:
  - O0..O9 hold the last completed vector until the next completion. They are never partially updated.
  - Signed values pass bit-exact; there is no arithmetic and no width change.
- Throughput: back-to-back series at full rate yield one vector per 2 cycles.
  - Beat 0 of the next series may be accepted in the same cycle that outReady is high.
- Gaps: idle cycles (inReady=0) between beat 0 and beat 1 are allowed. The state holds in WAIT_HI indefinitely.

Test Plan:
- Reset, then beat0 S=1,2,3,4,5 (inSeries=1) and beat1 S=6,7,8,9,-10 (inSeries=0) -> earlyOutReady=1 during beat1; next cycle outReady=1 with O0..O9=1..9,-10; following cycle outReady=0 and O held.
- Three series back-to-back with no gaps (values 10k+i) -> outReady pulses at cycles 2, 4, 6 with the correct vectors; readyForNewDataSeries alternates 1,0 each cycle.
- Beat0=A, 3 idle cycles, then enable=0 for 2 cycles with inReady=1, then beat1=B with enable=1 -> the frozen beats are ignored; a single outReady with O=A‖B.
- Beat with inSeries=0 while in WAIT_LO -> frameError pulse, O unchanged, readyForNewDataSeries stays 1. Beat0=A then beat0=C (inSeries=1), then beat1=D -> one frameError; output C‖D.
- Beat0 accepted, then reset asserted asynchronously mid-cycle -> all outputs 0 immediately. Next beat with inSeries=0 -> frameError (the partial series was lost).
- Extreme values, IN_WIDTH=10: beat0 all -512, beat1 all +511 -> O0..O4=-512 and O5..O9=511, bit-exact.
